// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider.
//   WIDTH      operand and result width
//   CNT_W      width of the iteration counter
//   LAST_ITER  counter value of the final iteration
//   state_t    controller states (IDLE, RUN, DONE)
package divider_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_divider_sub9.sv
// Trial subtractor for the restoring divider.
//   a, b  : 9-bit operands (zero-extended partial remainder and divisor)
//   diff  : a - b; bit 8 set means the trial went negative (borrow)
module sub9 (
    input  logic [8:0] a,
    input  logic [8:0] b,
    output logic [8:0] diff
);

    assign diff = a - b;

endmodule

// File: rtl/restoring_divider.sv
// 8-bit unsigned restoring divider, one quotient bit per clock.
//   Clk, Reset_n          : clock, asynchronous active-low reset
//   Start                 : begin a division (sampled only in IDLE)
//   Dividend, Divisor     : operands, captured on the accepting edge
//   Quotient, Remainder   : registered results, held until the next accepted Start
//   Busy                  : high whenever the controller is not IDLE
//   Done                  : one-cycle pulse marking valid results
//   DivByZero             : registered flag, set when the captured Divisor was 0
//
// state | meaning
// IDLE  | waiting for Start; results hold their last values
// RUN   | one shift/trial-subtract iteration per cycle, counter 0..7
// DONE  | results valid, Done asserted for this single cycle
module restoring_divider
    import divider_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   r_q,     r_d;
    logic [WIDTH-1:0]   q_q,     q_d;
    logic [WIDTH-1:0]   dvs_q,   dvs_d;
    logic [WIDTH-1:0]   quo_q,   quo_d;
    logic [WIDTH-1:0]   rem_q,   rem_d;
    logic               dbz_q,   dbz_d;

    logic [WIDTH-1:0]   r_sh;
    logic [WIDTH-1:0]   q_sh;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   r_iter;
    logic [WIDTH-1:0]   q_iter;

    // Shift {R,Q} left by one. The bit shifted out of R is always 0: before
    // the last iteration R is below 2^7, so the 9-bit trial loses nothing.
    assign r_sh = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign q_sh = {q_q[WIDTH-2:0], 1'b0};

    sub9 u_sub9 (
        .a    ({1'b0, r_sh}),
        .b    ({1'b0, dvs_q}),
        .diff (trial)
    );

    always_comb begin
        r_iter = r_sh;
        q_iter = q_sh;
        if (!trial[WIDTH]) begin
            r_iter = trial[WIDTH-1:0];
            q_iter = {q_sh[WIDTH-1:1], 1'b1};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = (Divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        r_d   = r_q;
        q_d   = q_q;
        dvs_d = dvs_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dbz_d = dbz_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    cnt_d = '0;
                    r_d   = '0;
                    q_d   = Dividend;
                    dvs_d = Divisor;
                    dbz_d = 1'b0;
                    if (Divisor == '0) begin
                        quo_d = '1;
                        rem_d = Dividend;
                        dbz_d = 1'b1;
                    end
                end
            end
            RUN: begin
                r_d   = r_iter;
                q_d   = q_iter;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    quo_d = q_iter;
                    rem_d = r_iter;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        Busy = (state_q != IDLE);
        Done = (state_q == DONE);
    end

    assign Quotient  = quo_q;
    assign Remainder = rem_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

    logic       Clk;
    logic       Reset_n;
    logic       Start;
    logic [7:0] Dividend;
    logic [7:0] Divisor;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       DivByZero;

    int n_checks = 0;
    int n_fail   = 0;

    restoring_divider dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; divide-by-zero yields all-ones and
    // passes the dividend through as remainder.
    function automatic logic [7:0] ref_quo(input logic [7:0] a, input logic [7:0] b);
        return (b == 0) ? 8'hFF : 8'(a / b);
    endfunction

    function automatic logic [7:0] ref_rem(input logic [7:0] a, input logic [7:0] b);
        return (b == 0) ? a : 8'(a % b);
    endfunction

    // Launch one division and check latency, results and the end of Busy.
    // Caller must be between clock edges with the DUT in IDLE.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input bit scramble);
        int n;
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        if (scramble) begin
            Dividend = 8'($urandom);
            Divisor  = 8'($urandom);
        end
        check_eq({tag, " busy_after_e0"}, Busy, 1'b1);
        n = 0;
        while (!Done && n < 20) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check_eq({tag, " latency"}, n, (b == 0) ? 0 : 8);
        check_eq({tag, " quotient"}, Quotient, ref_quo(a, b));
        check_eq({tag, " remainder"}, Remainder, ref_rem(a, b));
        check_eq({tag, " divbyzero"}, DivByZero, (b == 0));
        @(posedge Clk);
        #1;
        check_eq({tag, " done_one_cycle"}, Done, 1'b0);
        check_eq({tag, " idle_after"}, Busy, 1'b0);
        check_eq({tag, " result_hold"}, Quotient, ref_quo(a, b));
    endtask

    initial begin
        int done_cnt;
        int t_done[$];
        logic [7:0] a, b;

        Reset_n  = 1'b1;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        #1 Reset_n = 1'b0;
        #1;
        check_eq("reset quotient",  Quotient,  0);
        check_eq("reset remainder", Remainder, 0);
        check_eq("reset busy",      Busy,      0);
        check_eq("reset done",      Done,      0);
        check_eq("reset dbz",       DivByZero, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        run_op("100/7",   8'd100, 8'd7,   1'b1);
        run_op("255/1",   8'd255, 8'd1,   1'b0);
        run_op("255/255", 8'd255, 8'd255, 1'b0);
        run_op("5/9",     8'd5,   8'd9,   1'b0);
        run_op("200/0",   8'd200, 8'd0,   1'b1);
        run_op("200/10",  8'd200, 8'd10,  1'b0);
        run_op("0/3",     8'd0,   8'd3,   1'b0);
        run_op("254/255", 8'd254, 8'd255, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_op($sformatf("rand%0d %0d/%0d", i, a, b), a, b, 1'b1);
        end

        // Start pulsed mid-RUN with different operands must be ignored.
        @(negedge Clk);
        Dividend = 8'd100;
        Divisor  = 8'd7;
        Start    = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) begin
                Dividend = 8'd50;
                Divisor  = 8'd5;
                Start    = 1'b1;
            end
            if (c == 5) Start = 1'b0;
            @(posedge Clk);
            #1;
            if (Done) begin
                done_cnt++;
                check_eq("ignore quotient",  Quotient,  14);
                check_eq("ignore remainder", Remainder, 2);
            end
        end
        check_eq("ignore done_count", done_cnt, 1);

        // Reset asserted between edges in the middle of RUN.
        @(negedge Clk);
        Dividend = 8'd100;
        Divisor  = 8'd7;
        Start    = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (4) @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        check_eq("midrst quotient",  Quotient,  0);
        check_eq("midrst remainder", Remainder, 0);
        check_eq("midrst busy",      Busy,      0);
        check_eq("midrst done",      Done,      0);
        done_cnt = 0;
        repeat (3) begin
            @(posedge Clk);
            #1;
            if (Done) done_cnt++;
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (10) begin
            @(posedge Clk);
            #1;
            if (Done) done_cnt++;
        end
        check_eq("midrst no_done", done_cnt, 0);
        check_eq("midrst idle",    Busy,     0);
        run_op("9/3 after reset", 8'd9, 8'd3, 1'b0);

        // Start held high: a new operation every 10 cycles, none launched from DONE.
        @(negedge Clk);
        Dividend = 8'd100;
        Divisor  = 8'd7;
        Start    = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(posedge Clk);
            #1;
            if (Done) begin
                t_done.push_back(c);
                check_eq("held quotient",  Quotient,  14);
                check_eq("held remainder", Remainder, 2);
            end
        end
        Start = 1'b0;
        check_eq("held pulse_count", t_done.size(), 4);
        for (int k = 1; k < t_done.size(); k++)
            check_eq("held period", t_done[k] - t_done[k-1], 10);
        begin
            int n = 0;
            while (Busy && n < 20) begin
                @(posedge Clk);
                #1;
                n++;
            end
            check_eq("held drain", Busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
